// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: fifth pipeline stage, directly downstream of the data cache.
// Samples the cache readData bus once per stage period, in the phase where the cache
// drives it. Applies zero-extending load extraction, issues a one-cycle register-file
// write strobe, and keeps a forwarding copy of the last result for the hazard logic.
//
// Ports:
//   clock, reset_n     system clock (posedge) and asynchronous active-low reset
//   memReadData        cache readData: load data, or ALU result when memToReg=0
//   memToReg           1 = load result, apply size/lane extraction
//   regWrite           instruction writes a register
//   writeReg           destination register index
//   loadSize           00 word, 01 half, 10 byte, 11 treated as word
//   addrLow            load address bits [1:0], selects the byte/half lane
//   flush              cancel the result captured at this edge
//   phase              current stage phase, 0..STAGE_PERIOD-1
//   regWriteEn/Addr/Data  register-file write port (strobe is one cycle)
//   fwdValid/fwdReg/fwdData  forwarding copy of the last valid result
module mem_writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned STAGE_PERIOD   = 5,
    parameter int unsigned CAPTURE_PHASE  = 4,
    parameter int unsigned ZERO_REG       = 31
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     memReadData,
    input  logic                      memToReg,
    input  logic                      regWrite,
    input  logic [REG_ADDR_WIDTH-1:0] writeReg,
    input  logic [1:0]                loadSize,
    input  logic [1:0]                addrLow,
    input  logic                      flush,
    output logic [2:0]                phase,
    output logic                      regWriteEn,
    output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
    output logic [DATA_WIDTH-1:0]     regWriteData,
    output logic                      fwdValid,
    output logic [REG_ADDR_WIDTH-1:0] fwdReg,
    output logic [DATA_WIDTH-1:0]     fwdData
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned BYTE_W  = 8;

    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      fwd_valid_q, fwd_valid_d;
    logic [REG_ADDR_WIDTH-1:0] fwd_reg_q, fwd_reg_d;
    logic [DATA_WIDTH-1:0]     fwd_data_q, fwd_data_d;

    logic                      capture_c;
    logic                      valid_c;
    logic [DATA_WIDTH-1:0]     ext_data_c;

    // Load extraction; the result is only registered at the capture edge, so the
    // undriven bus in other phases never reaches state.
    always_comb begin
        ext_data_c = memReadData;
        if (memToReg) begin
            unique case (loadSize)
                2'b01:   ext_data_c = addrLow[1] ? DATA_WIDTH'(memReadData[2*HALF_W-1:HALF_W])
                                                 : DATA_WIDTH'(memReadData[HALF_W-1:0]);
                2'b10:   ext_data_c = DATA_WIDTH'(memReadData[{addrLow, 3'b000} +: BYTE_W]);
                default: ext_data_c = memReadData;
            endcase
        end
    end

    // Phase tracking, capture qualification and next-state for all outputs.
    always_comb begin
        phase_d     = (phase_q == PHASE_W'(STAGE_PERIOD - 1)) ? '0 : phase_q + PHASE_W'(1);
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fwd_valid_d = fwd_valid_q;
        fwd_reg_d   = fwd_reg_q;
        fwd_data_d  = fwd_data_q;

        capture_c = (phase_q == PHASE_W'(CAPTURE_PHASE));
        valid_c   = capture_c && regWrite && !flush &&
                    (writeReg != REG_ADDR_WIDTH'(ZERO_REG));

        if (capture_c) begin
            wr_en_d     = valid_c;
            wr_addr_d   = writeReg;
            wr_data_d   = ext_data_c;
            fwd_valid_d = valid_c;
            if (valid_c) begin
                fwd_reg_d  = writeReg;
                fwd_data_d = ext_data_c;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_reg_q   <= fwd_reg_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign phase        = phase_q;
    assign regWriteEn   = wr_en_q;
    assign regWriteAddr = wr_addr_q;
    assign regWriteData = wr_data_q;
    assign fwdValid     = fwd_valid_q;
    assign fwdReg       = fwd_reg_q;
    assign fwdData      = fwd_data_q;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: vector table, hand-written corner
// sequences and randomized cycles against a period/arithmetic reference model.
module tb_mem_writeback_stage;

    logic        clock;
    logic        reset_n;
    logic [31:0] memReadData;
    logic        memToReg;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [1:0]  loadSize;
    logic [1:0]  addrLow;
    logic        flush;
    logic [2:0]  phase;
    logic        regWriteEn;
    logic [4:0]  regWriteAddr;
    logic [31:0] regWriteData;
    logic        fwdValid;
    logic [4:0]  fwdReg;
    logic [31:0] fwdData;

    mem_writeback_stage dut (
        .clock(clock), .reset_n(reset_n), .memReadData(memReadData),
        .memToReg(memToReg), .regWrite(regWrite), .writeReg(writeReg),
        .loadSize(loadSize), .addrLow(addrLow), .flush(flush),
        .phase(phase), .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr),
        .regWriteData(regWriteData), .fwdValid(fwdValid), .fwdReg(fwdReg),
        .fwdData(fwdData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_cycle;   // clocks since reset release; phase = m_cycle % 5
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_fv;
    logic [4:0]  m_freg;
    logic [31:0] m_fdata;

    typedef struct {
        logic [31:0] data;
        logic        m2r;
        logic [1:0]  sz;
        logic [1:0]  al;
        logic [4:0]  wr;
        logic        rw;
        logic        fl;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_model(logic [31:0] d, logic m2r, logic [1:0] sz,
                                              logic [1:0] al);
        if (!m2r) return d;
        if (sz == 2'b01) return (d >> (16 * int'(al[1]))) & 32'h0000_FFFF;
        if (sz == 2'b10) return (d >> (8 * int'(al))) & 32'h0000_00FF;
        return d;
    endfunction

    function automatic int m_phase();
        return m_cycle % 5;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_en = 0; m_addr = 0; m_data = 0;
        m_fv = 0; m_freg = 0; m_fdata = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] e;
        logic        v;
        if (m_phase() == 4) begin
            e = ext_model(memReadData, memToReg, loadSize, addrLow);
            v = regWrite && !flush && (writeReg != 5'd31);
            m_en = v; m_addr = writeReg; m_data = e;
            m_fv = v;
            if (v) begin
                m_freg = writeReg; m_fdata = e;
            end
        end else begin
            m_en = 0;
        end
        m_cycle++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'(m_phase()));
        chk({tag, ".regWriteEn"}, 32'(regWriteEn), 32'(m_en));
        chk({tag, ".regWriteAddr"}, 32'(regWriteAddr), 32'(m_addr));
        chk({tag, ".regWriteData"}, regWriteData, m_data);
        chk({tag, ".fwdValid"}, 32'(fwdValid), 32'(m_fv));
        chk({tag, ".fwdReg"}, 32'(fwdReg), 32'(m_freg));
        chk({tag, ".fwdData"}, fwdData, m_fdata);
    endtask

    task automatic drive(input logic [31:0] d, input logic m2r, input logic [1:0] sz,
                         input logic [1:0] al, input logic [4:0] wr, input logic rw,
                         input logic fl);
        memReadData = d; memToReg = m2r; loadSize = sz; addrLow = al;
        writeReg = wr; regWrite = rw; flush = fl;
    endtask

    task automatic drive_garbage();
        drive($urandom, 1'($urandom), 2'($urandom), 2'($urandom), 5'($urandom % 31), 1'b1,
              1'($urandom));
    endtask

    // One clock: inputs already applied; model updates at the edge, compare at negedge.
    task automatic cycle(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(negedge clock);
        reset_n = 1'b1;
        check_all("reset_release");
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h0000_1234, 1'b0, 2'b00, 2'd0, 5'd3,  1'b1, 1'b0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{32'hC0DE_BABE, 1'b1, 2'b10, 2'd2, 5'd5,  1'b1, 1'b0, 1'b1, 32'h0000_00DE};
        vecs[2]  = '{32'hC0DE_BABE, 1'b1, 2'b01, 2'd1, 5'd6,  1'b1, 1'b0, 1'b1, 32'h0000_BABE};
        vecs[3]  = '{32'hC0DE_BABE, 1'b1, 2'b00, 2'd3, 5'd7,  1'b1, 1'b0, 1'b1, 32'hC0DE_BABE};
        vecs[4]  = '{32'hC0DE_BABE, 1'b1, 2'b11, 2'd1, 5'd8,  1'b1, 1'b0, 1'b1, 32'hC0DE_BABE};
        vecs[5]  = '{32'hC0DE_BABE, 1'b1, 2'b10, 2'd0, 5'd9,  1'b1, 1'b0, 1'b1, 32'h0000_00BE};
        vecs[6]  = '{32'hC0DE_BABE, 1'b1, 2'b10, 2'd3, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0000_00C0};
        vecs[7]  = '{32'hC0DE_BABE, 1'b1, 2'b01, 2'd3, 5'd11, 1'b1, 1'b0, 1'b1, 32'h0000_C0DE};
        vecs[8]  = '{32'hC0DE_BABE, 1'b0, 2'b10, 2'd1, 5'd0,  1'b1, 1'b0, 1'b1, 32'hC0DE_BABE};
        vecs[9]  = '{32'h1111_2222, 1'b0, 2'b00, 2'd0, 5'd31, 1'b1, 1'b0, 1'b0, 32'h1111_2222};
        vecs[10] = '{32'h3333_4444, 1'b0, 2'b00, 2'd0, 5'd12, 1'b1, 1'b1, 1'b0, 32'h3333_4444};
        vecs[11] = '{32'h5555_6666, 1'b0, 2'b00, 2'd0, 5'd13, 1'b0, 1'b0, 1'b0, 32'h5555_6666};

        reset_n = 1'b0;
        drive(32'h0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;

        // Idle run: phase sequence, all outputs zero.
        for (int i = 0; i < 10; i++) cycle("idle");

        // Vector table: garbage (regWrite=1) in phases 0-3, vector in phase 4.
        foreach (vecs[k]) begin
            while (m_phase() != 4) begin
                drive_garbage();
                cycle("garbage");
                chk("garbage_no_strobe", 32'(regWriteEn), 32'(m_phase() == 0 && m_en));
            end
            drive(vecs[k].data, vecs[k].m2r, vecs[k].sz, vecs[k].al, vecs[k].wr,
                  vecs[k].rw, vecs[k].fl);
            cycle("vec");
            chk($sformatf("vec%0d.en", k), 32'(regWriteEn), 32'(vecs[k].exp_en));
            chk($sformatf("vec%0d.data", k), regWriteData, vecs[k].exp_data);
            chk($sformatf("vec%0d.fwdValid", k), 32'(fwdValid), 32'(vecs[k].exp_en));
            if (vecs[k].exp_en)
                chk($sformatf("vec%0d.fwdData", k), fwdData, vecs[k].exp_data);
        end

        // Flush asserted only in phase 2 is ignored; the write still occurs.
        while (m_phase() != 0) begin drive(32'h0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0); cycle("align"); end
        for (int p = 0; p < 5; p++) begin
            drive(32'hABCD_0123, 1'b0, 2'b00, 2'b00, 5'd14, 1'b1, p == 2);
            cycle("flush_ph2");
        end
        chk("flush_ph2.en", 32'(regWriteEn), 32'd1);
        chk("flush_ph2.data", regWriteData, 32'hABCD_0123);
        // Forward copy holds through the following period while regWrite is off.
        for (int p = 0; p < 4; p++) begin
            drive($urandom, 1'b0, 2'b00, 2'b00, 5'd2, 1'b0, 1'b0);
            cycle("fwd_hold");
            chk("fwd_hold.data", fwdData, 32'hABCD_0123);
        end

        // Valid capture, then async reset in the middle of phase 2.
        while (m_phase() != 4) begin drive(32'h0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b0, 1'b0); cycle("align"); end
        drive(32'h0BAD_F00D, 1'b0, 2'b00, 2'b00, 5'd20, 1'b1, 1'b0);
        cycle("pre_reset");
        chk("pre_reset.fwdValid", 32'(fwdValid), 32'd1);
        drive(32'h0BAD_F00D, 1'b0, 2'b00, 2'b00, 5'd20, 1'b1, 1'b0);
        cycle("pre_reset");
        cycle("pre_reset");
        apply_reset();
        chk("post_reset.fwdValid", 32'(fwdValid), 32'd0);
        begin
            int n;
            n = 0;
            while (n < 10 && !regWriteEn) begin
                cycle("relatch");
                n++;
            end
            chk("strobe_latency_after_reset", 32'(n), 32'd5);
        end

        // Randomized cycles against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom, 1'($urandom), 2'($urandom), 2'($urandom),
                  ($urandom % 4 == 0) ? 5'd31 : 5'($urandom), 1'($urandom % 4 != 0),
                  1'($urandom % 5 == 0));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
